// File: rtl/larpix_cmd_pkg.sv
// Shared encodings, packet layout and FSM state type for the LArPix command scheduler.
package larpix_cmd_pkg;

  localparam logic [1:0]  OP_WRITE     = 2'd2;
  localparam logic [1:0]  OP_READ      = 2'd3;
  localparam logic [31:0] MAGIC_NUMBER = 32'h8950_4E47;

  // Packet field offsets (LSB positions)
  localparam int OP_LSB    = 0;
  localparam int CHIP_LSB  = 2;
  localparam int ADDR_LSB  = 10;
  localparam int DATA_LSB  = 18;
  localparam int MAGIC_LSB = 26;
  localparam int PAR_BIT   = 63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  // Assemble a 64-bit packet; reads carry zero data, top bit forces odd overall parity.
  function automatic logic [63:0] build_packet(input logic [1:0] op, input logic [7:0] chip_id,
                                               input logic [7:0] addr, input logic [7:0] data);
    logic [63:0] p;
    p = '0;
    p[OP_LSB +: 2]     = op;
    p[CHIP_LSB +: 8]   = chip_id;
    p[ADDR_LSB +: 8]   = addr;
    p[DATA_LSB +: 8]   = (op == OP_READ) ? 8'h00 : data;
    p[MAGIC_LSB +: 32] = MAGIC_NUMBER;
    p[PAR_BIT]         = ~^p[PAR_BIT-1:0];
    return p;
  endfunction

endpackage

// File: rtl/larpix_cmd_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer advances past the winner on accept.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    accept,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;

  // Wrapping search starting at the pointer
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  // Pointer moves to the requester after the one just accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (accept && any)
      ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/larpix_cmd_scheduler.sv
// Arbitrates LArPix config commands from several requesters onto one UART TX,
// building framed packets and pacing them with busy handshake, timeout and inter-packet gap.
module larpix_cmd_scheduler
  import larpix_cmd_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int WIDTH        = 64,
  parameter int GAP_CYCLES   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_chip_id,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  output logic [WIDTH-1:0]  tx_data,
  output logic              ld_tx_data,
  input  logic              tx_busy,
  output logic              err_bad_op,
  output logic              err_timeout,
  output logic [15:0]       pkt_count
);

  localparam logic [15:0] TMO_LAST = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t                    state, state_nxt;
  logic [NREQ-1:0]           grant;
  logic [$clog2(NREQ)-1:0]   gidx;
  logic                      any_req, accept, op_ok, tmo_hit;
  logic [1:0]                g_op;
  logic [7:0]                g_chip, g_addr, g_data;
  logic [15:0]               tmo_cnt, gap_cnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (reset),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (gidx),
    .any       (any_req)
  );

  assign accept  = (state == ST_IDLE) && any_req;
  assign g_op    = req_op[2*int'(gidx) +: 2];
  assign g_chip  = req_chip_id[8*int'(gidx) +: 8];
  assign g_addr  = req_addr[8*int'(gidx) +: 8];
  assign g_data  = req_data[8*int'(gidx) +: 8];
  assign op_ok   = g_op[1];  // only 2 (write) and 3 (read) are real packets
  assign tmo_hit = (state == ST_WAIT_BUSY) && !tx_busy && (tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (accept) state_nxt = op_ok ? ST_LOAD : ST_IDLE;
      ST_LOAD:      state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy) state_nxt = ST_WAIT_DONE;
                    else if (tmo_hit) state_nxt = ST_GAP;
      ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_GAP;
      ST_GAP:       if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; ready is masked during reset since the state already reads IDLE then
  always_comb begin
    req_ready   = '0;
    ld_tx_data  = 1'b0;
    err_timeout = 1'b0;
    if (state == ST_IDLE && !reset) req_ready = grant;
    if (state == ST_LOAD)           ld_tx_data = 1'b1;
    err_timeout = tmo_hit;
  end

  // Packet capture, counters and bad-op pulse; tx_data is valid in the LOAD cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data    <= '0;
      pkt_count  <= '0;
      err_bad_op <= 1'b0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      err_bad_op <= accept && !op_ok;
      if (accept && op_ok) begin
        tx_data   <= WIDTH'(build_packet(g_op, g_chip, g_addr, g_data));
        pkt_count <= pkt_count + 16'd1;
      end
      tmo_cnt <= (state == ST_WAIT_BUSY) ? tmo_cnt + 16'd1 : 16'd0;
      gap_cnt <= (state == ST_GAP)       ? gap_cnt + 16'd1 : 16'd0;
    end
  end

endmodule

// File: tb/tb_larpix_cmd_scheduler.sv
// Directed bench for larpix_cmd_scheduler with a UART busy model and hand-computed expectations.
module tb_larpix_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_chip_id, req_addr, req_data;
  logic [63:0] tx_data;
  logic        ld_tx_data, tx_busy, err_bad_op, err_timeout;
  logic [15:0] pkt_count;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_len = 0;
  int busy_left = 0;
  logic ld_q_n = 1'b0;
  logic mon_en = 1'b0;
  int lds[$];
  int tmos[$];
  logic [1:0]  grants[$];
  logic [63:0] txs[$];
  logic [63:0] pk;

  larpix_cmd_scheduler #(.NREQ(2), .WIDTH(64), .GAP_CYCLES(4), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_chip_id(req_chip_id), .req_addr(req_addr), .req_data(req_data),
    .tx_data(tx_data), .ld_tx_data(ld_tx_data), .tx_busy(tx_busy),
    .err_bad_op(err_bad_op), .err_timeout(err_timeout), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // UART model: busy for busy_len cycles starting the cycle after a load strobe
  always @(negedge clk) ld_q_n = ld_tx_data;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_left = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (ld_q_n && busy_len > 0) busy_left = busy_len;
    end
    tx_busy = (busy_left > 0);
  end

  // Event log
  always @(negedge clk) if (mon_en) begin
    if (req_ready != 2'b00) grants.push_back(req_ready);
    if (ld_tx_data) begin lds.push_back(cyc); txs.push_back(tx_data); end
    if (err_timeout) tmos.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    lds.delete(); tmos.delete(); grants.delete(); txs.delete();
  endtask

  // Present one command for exactly one accept cycle
  task automatic send1(input int r, input logic [1:0] op, input logic [7:0] chip,
                       input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    req_op[2*r +: 2]      = op;
    req_chip_id[8*r +: 8] = chip;
    req_addr[8*r +: 8]    = addr;
    req_data[8*r +: 8]    = data;
    req_valid[r]          = 1'b1;
    #1 chk("ready_onehot", 64'(req_ready), 64'(1) << r);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tx_busy = 1'b0;
    req_valid = 2'b11; req_op = 4'hE; req_chip_id = '0; req_addr = '0; req_data = '0;
    mon_en = 1'b1;

    // Reset values, with requests pending to make ready meaningful
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_ld", 64'(ld_tx_data), 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_cnt", 64'(pkt_count), 0);
    chk("rst_badop", 64'(err_bad_op), 0);
    chk("rst_tmo", 64'(err_timeout), 0);
    req_valid = 2'b00;
    @(posedge clk); #2 rst = 1'b0;

    // Single write, long busy
    busy_len = 66;
    send1(0, 2'd2, 8'h10, 8'h01, 8'hA5);
    @(negedge clk);
    chk("t1_ld", 64'(ld_tx_data), 1);
    chk("t1_pkt", tx_data, 64'h8225_4139_1E94_0442);
    chk("t1_parity", 64'(^tx_data), 1);
    pk = tx_data;
    chk("t1_magic", 64'(pk[57:26]), 64'h8950_4E47);
    @(negedge clk);
    chk("t1_ld_off", 64'(ld_tx_data), 0);
    chk("t1_cnt", 64'(pkt_count), 1);
    chk("t1_hold", tx_data, 64'h8225_4139_1E94_0442);
    repeat (85) @(negedge clk);

    // Two requesters always valid: alternating grants, fixed packet spacing
    rst = 1'b1;
    req_op = {2'd3, 2'd2}; req_chip_id = {8'h02, 8'h01};
    req_addr = {8'h22, 8'h11}; req_data = {8'h55, 8'h44};
    req_valid = 2'b11; busy_len = 10;
    @(posedge clk); clr_log(); #2 rst = 1'b0;
    for (int i = 0; i < 300 && lds.size() < 6; i++) begin @(negedge clk); #1; end
    req_valid = 2'b00;
    chk("t2_nld", 64'(lds.size()), 6);
    chk("t2_ngrant", 64'(grants.size()), 6);
    if (lds.size() >= 6 && grants.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("t2_grant%0d", i), 64'(grants[i]), (i % 2) ? 2 : 1);
      for (int i = 0; i < 5; i++) chk($sformatf("t2_space%0d", i), 64'(lds[i+1] - lds[i]), 17);
      pk = txs[0];
      chk("t2_wr_data", 64'(pk[25:18]), 8'h44);
      pk = txs[1];
      chk("t2_rd_op", 64'(pk[1:0]), 3);
      chk("t2_rd_data", 64'(pk[25:18]), 0);
      chk("t2_rd_chip", 64'(pk[9:2]), 8'h02);
    end
    @(negedge clk);
    chk("t2_cnt", 64'(pkt_count), 6);
    repeat (30) @(negedge clk);

    // tx_busy stuck low: timeout, gap, then the other requester is served
    busy_len = 0; clr_log();
    req_valid = 2'b11;
    for (int i = 0; i < 100 && lds.size() < 2; i++) begin @(negedge clk); #1; end
    req_valid = 2'b00;
    chk("t3_nld", 64'(lds.size()), 2);
    chk("t3_ntmo", 64'(tmos.size() >= 1), 1);
    if (lds.size() >= 2 && tmos.size() >= 1 && grants.size() >= 2) begin
      chk("t3_tmo_lat", 64'(tmos[0] - lds[0]), 8);
      chk("t3_next_ld", 64'(lds[1] - lds[0]), 14);
      chk("t3_grant0", 64'(grants[0]), 1);
      chk("t3_grant1", 64'(grants[1]), 2);
    end
    repeat (20) @(negedge clk);
    chk("t3_ntmo2", 64'(tmos.size()), 2);
    chk("t3_cnt", 64'(pkt_count), 8);

    // Illegal op: error pulse only
    clr_log();
    send1(0, 2'd1, 8'h05, 8'h06, 8'h07);
    @(negedge clk);
    chk("t4_badop", 64'(err_bad_op), 1);
    chk("t4_no_ld", 64'(ld_tx_data), 0);
    @(negedge clk);
    chk("t4_badop_off", 64'(err_bad_op), 0);
    repeat (10) @(negedge clk);
    chk("t4_nld", 64'(lds.size()), 0);
    chk("t4_cnt", 64'(pkt_count), 8);

    // Reset in the middle of WAIT_DONE, then a fresh request
    busy_len = 66;
    send1(1, 2'd2, 8'h21, 8'h02, 8'h03);
    repeat (6) @(negedge clk);
    chk("t5_busy", 64'(tx_busy), 1);
    req_op[3:2] = 2'd2; req_chip_id[15:8] = 8'h33; req_addr[15:8] = 8'h44; req_data[15:8] = 8'h66;
    req_valid[1] = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("t5_ready", 64'(req_ready), 0);
    chk("t5_ld", 64'(ld_tx_data), 0);
    chk("t5_txdata", tx_data, 0);
    chk("t5_cnt", 64'(pkt_count), 0);
    chk("t5_errs", 64'({err_bad_op, err_timeout}), 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_regrant", 64'(req_ready), 2);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5_ld_new", 64'(ld_tx_data), 1);
    pk = tx_data;
    chk("t5_chip", 64'(pk[9:2]), 8'h33);
    @(negedge clk);
    chk("t5_cnt_new", 64'(pkt_count), 1);
    repeat (90) @(negedge clk);

    // Packet counter wraps
    busy_len = 2;
    @(negedge clk);
    force dut.pkt_count = 16'hFFFF;
    #1 release dut.pkt_count;
    #1 chk("t6_preload", 64'(pkt_count), 16'hFFFF);
    send1(0, 2'd3, 8'hFF, 8'h09, 8'h0A);
    @(negedge clk);
    chk("t6_ld", 64'(ld_tx_data), 1);
    pk = tx_data;
    chk("t6_bcast", 64'(pk[9:2]), 8'hFF);
    @(negedge clk);
    chk("t6_wrap", 64'(pkt_count), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
